// File: rtl/t5_pctl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : t5_pctl
// Description : Pipeline control for a five-stage core. Sequences boot,
//               handles memory stalls, fetch stalls, branch flushes and
//               load-use hazards, and counts stalled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module t5_pctl #(
    parameter int BOOT = 4          // boot cycles with sena=0, 1..16
) (
    input  logic        sclk,
    input  logic        srst,
    input  logic        iack,
    input  logic        dreq,
    input  logic        dack,
    input  logic        xbra,
    input  logic [4:0]  xopc,
    input  logic [4:0]  xrd,
    input  logic [4:0]  drs1,
    input  logic [4:0]  drs2,
    input  logic        cclr,
    output logic        sena,
    output logic        fena,
    output logic        fkil,
    output logic        dnop,
    output logic [2:0]  pst,
    output logic [15:0] cstl
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_RUN   = 3'd1,
        S_LDST  = 3'd2,
        S_FLSH  = 3'd3,
        S_MWAIT = 3'd4
    } state_t;

    // Boot counter reload value; counter reads 0 in the last boot cycle.
    localparam logic [3:0] c_BOOT_LOAD = 4'(BOOT - 1);
    localparam logic [15:0] c_CSTL_MAX = 16'hFFFF;

    state_t      state_q, state_d;
    logic [3:0]  bcnt_q,  bcnt_d;
    logic [15:0] cstl_q,  cstl_d;

    logic   w_mstall;
    logic   w_hz;
    // Result of the RUN decision ignoring the memory stall; reused when a
    // memory wait finishes so a pending branch or hazard is not dropped.
    logic   w_rr_sena, w_rr_fena, w_rr_fkil, w_rr_dnop;
    state_t w_rr_next;
    logic   w_go;

    // Stall/hazard detection and the shared RUN priorities 2..5.
    always_comb begin
        w_mstall  = dreq & ~dack;
        // Load in execute whose destination feeds either decode source.
        w_hz      = (xopc == 5'h00) & (xrd != 5'd0) &
                    ((xrd == drs1) | (xrd == drs2));
        w_go      = iack & ~w_mstall;
        w_rr_sena = 1'b0;
        w_rr_fena = 1'b0;
        w_rr_fkil = 1'b0;
        w_rr_dnop = 1'b0;
        w_rr_next = S_RUN;
        if (!iack) begin
            w_rr_next = S_RUN;
        end else if (xbra) begin
            w_rr_sena = 1'b1;
            w_rr_fena = 1'b1;
            w_rr_fkil = 1'b1;
            w_rr_dnop = 1'b1;
            w_rr_next = S_FLSH;
        end else if (w_hz) begin
            w_rr_sena = 1'b1;
            w_rr_dnop = 1'b1;
            w_rr_next = S_LDST;
        end else begin
            w_rr_sena = 1'b1;
            w_rr_fena = 1'b1;
        end
    end

    // Next-state and pipeline control outputs.
    always_comb begin
        state_d = state_q;
        sena    = 1'b0;
        fena    = 1'b0;
        fkil    = 1'b0;
        dnop    = 1'b0;
        case (state_q)
            S_BOOT: begin
                fkil = 1'b1;
                dnop = 1'b1;
                if (bcnt_q == 4'd0) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_mstall) begin
                    state_d = S_MWAIT;
                end else begin
                    sena    = w_rr_sena;
                    fena    = w_rr_fena;
                    fkil    = w_rr_fkil;
                    dnop    = w_rr_dnop;
                    state_d = w_rr_next;
                end
            end
            S_FLSH: begin
                sena = w_go;
                fena = w_go;
                fkil = 1'b1;
                dnop = 1'b1;
                if (w_go) begin
                    state_d = S_RUN;
                end
            end
            S_LDST: begin
                sena = w_go;
                fena = w_go;
                if (w_go) begin
                    state_d = S_RUN;
                end
            end
            S_MWAIT: begin
                if (dack) begin
                    sena    = w_rr_sena;
                    fena    = w_rr_fena;
                    fkil    = w_rr_fkil;
                    dnop    = w_rr_dnop;
                    state_d = w_rr_next;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
        // Reset forces the boot-time output pattern regardless of state.
        if (srst) begin
            sena    = 1'b0;
            fena    = 1'b0;
            fkil    = 1'b1;
            dnop    = 1'b1;
            state_d = S_BOOT;
        end
    end

    // Boot countdown and saturating stall counter next values.
    always_comb begin
        if ((state_q == S_BOOT) && (bcnt_q != 4'd0)) begin
            bcnt_d = bcnt_q - 4'd1;
        end else begin
            bcnt_d = c_BOOT_LOAD;
        end
        cstl_d = cstl_q;
        if (cclr) begin
            cstl_d = 16'd0;
        end else if (!sena && (state_q != S_BOOT) && (cstl_q != c_CSTL_MAX)) begin
            cstl_d = cstl_q + 16'd1;
        end
    end

    // State, boot counter and stall counter registers.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= S_BOOT;
            bcnt_q  <= c_BOOT_LOAD;
            cstl_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            cstl_q  <= cstl_d;
        end
    end

    assign pst  = state_q;
    assign cstl = cstl_q;

endmodule
`default_nettype wire

// File: tb/tb_t5_pctl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_t5_pctl
// Description : Directed scoreboard bench for t5_pctl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t5_pctl;

    logic        sclk = 1'b0;
    logic        srst, iack, dreq, dack, xbra, cclr;
    logic [4:0]  xopc, xrd, drs1, drs2;
    logic        sena, fena, fkil, dnop;
    logic [2:0]  pst;
    logic [15:0] cstl;

    typedef struct {
        string       nm;
        logic [22:0] exp;   // {pst, sena, fena, fkil, dnop, cstl}
    } ent_t;

    ent_t        sb[$];
    ent_t        m_e;
    logic [22:0] m_act;
    int          n_tot = 0;
    int          n_bad = 0;
    logic [15:0] e_cstl = 16'd0;

    t5_pctl #(.BOOT(4)) u_dut (
        .sclk (sclk),
        .srst (srst),
        .iack (iack),
        .dreq (dreq),
        .dack (dack),
        .xbra (xbra),
        .xopc (xopc),
        .xrd  (xrd),
        .drs1 (drs1),
        .drs2 (drs2),
        .cclr (cclr),
        .sena (sena),
        .fena (fena),
        .fkil (fkil),
        .dnop (dnop),
        .pst  (pst),
        .cstl (cstl)
    );

    always #5 sclk = ~sclk;

    // Monitor: compare every presented cycle against the scoreboard head.
    always @(negedge sclk) begin
        if (sb.size() != 0) begin
            m_e   = sb.pop_front();
            m_act = {pst, sena, fena, fkil, dnop, cstl};
            n_tot++;
            if (m_act !== m_e.exp) begin
                n_bad++;
                $display("FAIL %s: got pst=%0d sena=%b fena=%b fkil=%b dnop=%b cstl=%h, want pst=%0d sena=%b fena=%b fkil=%b dnop=%b cstl=%h",
                         m_e.nm, m_act[22:20], m_act[19], m_act[18], m_act[17], m_act[16], m_act[15:0],
                         m_e.exp[22:20], m_e.exp[19], m_e.exp[18], m_e.exp[17], m_e.exp[16], m_e.exp[15:0]);
            end
        end
    end

    // Called at posedge+1 with inputs already applied; queues the expected
    // outputs for this cycle, then advances the stall-count expectation.
    task automatic step(input string nm, input bit chk, input logic [2:0] p,
                        input logic s, input logic f, input logic k, input logic d);
        ent_t e;
        if (chk) begin
            e.nm  = nm;
            e.exp = {p, s, f, k, d, e_cstl};
            sb.push_back(e);
        end
        if (srst || cclr) begin
            e_cstl = 16'd0;
        end else if (!s && (p != 3'd0) && (e_cstl != 16'hFFFF)) begin
            e_cstl = e_cstl + 16'd1;
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic idle();
        iack = 1'b1; dreq = 1'b0; dack = 1'b0; xbra = 1'b0; cclr = 1'b0;
        xopc = 5'h04; xrd = 5'd0; drs1 = 5'd0; drs2 = 5'd0;
    endtask

    // Bound on total run time.
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        srst = 1'b1;
        idle();
        @(posedge sclk);
        #1;
        // Reset holds boot pattern
        step("rst0", 1, 3'd0, 0, 0, 1, 1);
        step("rst1", 1, 3'd0, 0, 0, 1, 1);
        // Boot: exactly four cycles then RUN
        srst = 1'b0;
        for (int i = 0; i < 4; i++) step("boot", 1, 3'd0, 0, 0, 1, 1);
        step("run", 1, 3'd1, 1, 1, 0, 0);

        // Branch flush
        xbra = 1'b1;
        step("bra", 1, 3'd1, 1, 1, 1, 1);
        xbra = 1'b0;
        step("flsh", 1, 3'd3, 1, 1, 1, 1);
        step("flsh_end", 1, 3'd1, 1, 1, 0, 0);

        // Load-use hazard on drs2
        xopc = 5'h00; xrd = 5'd5; drs2 = 5'd5;
        step("hz", 1, 3'd1, 1, 0, 0, 1);
        idle();
        step("ldst", 1, 3'd2, 1, 1, 0, 0);
        step("ldst_end", 1, 3'd1, 1, 1, 0, 0);
        // x0 destination never stalls
        xopc = 5'h00; xrd = 5'd0; drs2 = 5'd0;
        step("hz_x0", 1, 3'd1, 1, 1, 0, 0);
        // Hazard on drs1, LDST held by fetch stall
        xopc = 5'h00; xrd = 5'd7; drs1 = 5'd7; drs2 = 5'd3;
        step("hz1", 1, 3'd1, 1, 0, 0, 1);
        idle();
        iack = 1'b0;
        step("ldst_wait", 1, 3'd2, 0, 0, 0, 0);
        iack = 1'b1;
        step("ldst_go", 1, 3'd2, 1, 1, 0, 0);
        step("run2", 1, 3'd1, 1, 1, 0, 0);
        // Fetch stall in RUN
        iack = 1'b0;
        step("nofetch", 1, 3'd1, 0, 0, 0, 0);
        iack = 1'b1;
        step("run3", 1, 3'd1, 1, 1, 0, 0);

        // Memory stall with branch held: dack on the third wait
        xbra = 1'b1; dreq = 1'b1;
        step("mst", 1, 3'd1, 0, 0, 0, 0);
        step("mw1", 1, 3'd4, 0, 0, 0, 0);
        step("mw2", 1, 3'd4, 0, 0, 0, 0);
        dack = 1'b1;
        step("mw_ack_bra", 1, 3'd4, 1, 1, 1, 1);
        idle();
        step("mw_flsh", 1, 3'd3, 1, 1, 1, 1);
        step("mw_run", 1, 3'd1, 1, 1, 0, 0);
        // Memory stall with hazard pending
        dreq = 1'b1; xopc = 5'h00; xrd = 5'd9; drs1 = 5'd9;
        step("mst_hz", 1, 3'd1, 0, 0, 0, 0);
        dack = 1'b1;
        step("mw_ack_hz", 1, 3'd4, 1, 0, 0, 1);
        idle();
        step("mw_ldst", 1, 3'd2, 1, 1, 0, 0);
        step("mw_run2", 1, 3'd1, 1, 1, 0, 0);

        // Reset mid-MWAIT, late dack ignored
        dreq = 1'b1;
        step("mst_r", 1, 3'd1, 0, 0, 0, 0);
        step("mw_r", 1, 3'd4, 0, 0, 0, 0);
        srst = 1'b1;
        step("rst_mw", 1, 3'd4, 0, 0, 1, 1);
        srst = 1'b0; dack = 1'b1;
        step("reboot0", 1, 3'd0, 0, 0, 1, 1);
        idle();
        for (int i = 0; i < 3; i++) step("reboot", 1, 3'd0, 0, 0, 1, 1);
        step("rerun", 1, 3'd1, 1, 1, 0, 0);

        // Stall counter saturation and clear
        iack = 1'b0;
        for (int i = 0; i < 65540; i++) step("sat_fill", 0, 3'd1, 0, 0, 0, 0);
        step("sat_hold0", 1, 3'd1, 0, 0, 0, 0);
        step("sat_hold1", 1, 3'd1, 0, 0, 0, 0);
        cclr = 1'b1;
        step("cclr", 1, 3'd1, 0, 0, 0, 0);
        cclr = 1'b0;
        step("after_cclr", 1, 3'd1, 0, 0, 0, 0);
        step("recount", 1, 3'd1, 0, 0, 0, 0);
        iack = 1'b1;
        step("final", 1, 3'd1, 1, 1, 0, 0);

        @(negedge sclk);
        #1;
        n_tot++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
